// File: rtl/conv1_frame_sched.sv
// conv1_frame_sched
//
// Frame sequencer for the first convolution stage of the MNIST CNN.
// When a start request arrives, it reads one WIDTHxHEIGHT image from a
// synchronous pixel memory at one pixel per clock, with no gaps, and feeds it
// to the conv-1 window buffer. It also follows the FILTER_SIZE x FILTER_SIZE
// windows that the buffer reports. Each window is tagged with its output row
// and column, and the final window is flagged. A drain watchdog sets a sticky
// error if the buffer goes quiet before the frame is complete.
//
// Ports
//   clk, rst_n     rising-edge clock, synchronous active-low reset
//   start          frame request, only honoured in IDLE
//   img_base       address of pixel 0, captured when start is accepted
//   busy           high while a frame is in flight (FETCH, DRAIN, DONE)
//   done           one-cycle completion pulse
//   error          sticky watchdog flag, cleared by the next accepted start
//   mem_rd_en      pixel memory read strobe
//   mem_addr       pixel memory read address (wraps modulo 2^ADDR_BITS)
//   mem_rd_data    pixel memory data, valid the cycle after mem_rd_en
//   pix_out        pixel to the window buffer
//   pix_valid      pix_out carries a frame pixel
//   win_valid_in   window-valid flag coming back from the window buffer
//   out_valid      current window belongs to this frame
//   out_row        output row of the current window
//   out_col        output column of the current window
//   out_last       current window is the last one of the frame
module conv1_frame_sched #(
   parameter int WIDTH       = 28,
   parameter int HEIGHT      = 28,
   parameter int FILTER_SIZE = 5,
   parameter int DATA_BITS   = 8,
   parameter int ADDR_BITS   = 16,
   parameter int TIMEOUT     = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [ADDR_BITS-1:0] img_base,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic                 mem_rd_en,
   output logic [ADDR_BITS-1:0] mem_addr,
   input  logic [DATA_BITS-1:0] mem_rd_data,
   output logic [DATA_BITS-1:0] pix_out,
   output logic                 pix_valid,
   input  logic                 win_valid_in,
   output logic                 out_valid,
   output logic [4:0]           out_row,
   output logic [4:0]           out_col,
   output logic                 out_last
);

   localparam int NPIX     = WIDTH * HEIGHT;
   localparam int NWIN     = (WIDTH - FILTER_SIZE + 1) * (HEIGHT - FILTER_SIZE + 1);
   localparam int PIX_BITS = $clog2(NPIX);
   localparam int WIN_BITS = $clog2(NWIN + 1);
   localparam int WD_BITS  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN,
      DONE
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [ADDR_BITS-1:0] base;
   logic [PIX_BITS-1:0]  pix_cnt;
   logic [WIN_BITS-1:0]  win_cnt;
   logic [4:0]           row;
   logic [4:0]           col;
   logic [WD_BITS-1:0]   wdog;
   logic [WD_BITS-1:0]   wdog_inc;
   logic                 tracking;
   logic                 last_pix;
   logic                 wdog_expire;

   // State register. A reset in the middle of a frame drops straight back
   // to IDLE, so no done pulse is produced for an aborted frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and output decode. The window tag outputs are driven
   // combinationally from win_valid_in and the registered row/col counters,
   // so they line up with the cycle in which the window buffer presents its
   // data. Windows are only accepted in FETCH and DRAIN. A window and a
   // watchdog expiry cannot both happen in one cycle, because expiry needs an
   // idle cycle. If the final window arrives on the cycle expiry was due, the
   // window is taken and error stays clear.
   always_comb begin
      state_nxt   = state;
      busy        = (state != IDLE);
      done        = (state == DONE);
      mem_rd_en   = (state == FETCH);
      mem_addr    = '0;
      pix_out     = '0;
      tracking    = (state == FETCH) || (state == DRAIN);
      out_valid   = tracking && win_valid_in;
      out_row     = '0;
      out_col     = '0;
      out_last    = 1'b0;
      last_pix    = (pix_cnt == PIX_BITS'(NPIX - 1));
      wdog_inc    = wdog + 1'b1;
      wdog_expire = (state == DRAIN) && !win_valid_in && (wdog_inc == WD_BITS'(TIMEOUT));

      if (mem_rd_en) begin
         mem_addr = base + ADDR_BITS'(pix_cnt);
      end
      if (pix_valid) begin
         pix_out = mem_rd_data;
      end
      if (out_valid) begin
         out_row  = row;
         out_col  = col;
         out_last = (win_cnt == WIN_BITS'(NWIN - 1));
      end

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            if (last_pix) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (out_last || wdog_expire) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath registers. pix_valid is the read strobe delayed by one stage,
   // which matches the one-cycle read latency of the pixel memory. The frame
   // counters are cleared only when a new start is accepted, so their values
   // stay visible after a frame ends. The watchdog advances only in DRAIN.
   // During FETCH the buffer is still being filled, so a gap between windows
   // is expected there.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         base      <= '0;
         pix_cnt   <= '0;
         win_cnt   <= '0;
         row       <= '0;
         col       <= '0;
         wdog      <= '0;
         error     <= 1'b0;
         pix_valid <= 1'b0;
      end else begin
         pix_valid <= mem_rd_en;

         case (state)
            IDLE: begin
               if (start) begin
                  base    <= img_base;
                  error   <= 1'b0;
                  pix_cnt <= '0;
                  win_cnt <= '0;
                  row     <= '0;
                  col     <= '0;
                  wdog    <= '0;
               end
            end
            FETCH: begin
               if (!last_pix) begin
                  pix_cnt <= pix_cnt + 1'b1;
               end
            end
            DRAIN: begin
               if (win_valid_in) begin
                  wdog <= '0;
               end else begin
                  wdog <= wdog_inc;
               end
               if (wdog_expire) begin
                  error <= 1'b1;
               end
            end
            default: begin
            end
         endcase

         if (out_valid) begin
            win_cnt <= win_cnt + 1'b1;
            if (col == 5'(WIDTH - FILTER_SIZE)) begin
               col <= '0;
               row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_conv1_frame_sched.sv
// tb_conv1_frame_sched
//
// Self-checking bench for conv1_frame_sched. It contains a synchronous pixel
// memory model, whose data is derived from the address, and a raster model of
// the window buffer. The raster model raises win_valid_in for every pixel in
// row >= 4 and column >= 4. A manual window mode is also provided for the
// watchdog scenario. For each frame started, the expected read addresses,
// pixels and window tags are queued. A negedge monitor pops and compares them
// as the DUT produces them. Each scenario task checks its own timing and
// counts.
module tb_conv1_frame_sched;

   localparam int NPIX    = 784;
   localparam int NWIN    = 576;
   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] img_base = '0;
   logic        busy;
   logic        done;
   logic        error;
   logic        mem_rd_en;
   logic [15:0] mem_addr;
   logic [7:0]  mem_rd_data = '0;
   logic [7:0]  pix_out;
   logic        pix_valid;
   logic        win_valid_in;
   logic        out_valid;
   logic [4:0]  out_row;
   logic [4:0]  out_col;
   logic        out_last;

   int n_cmp = 0;
   int n_bad = 0;
   int done_seen = 0;
   int pv_seen = 0;
   int pcnt = 0;
   bit sb_en = 1'b1;
   bit win_mode = 1'b0;
   bit win_manual = 1'b0;
   bit raster_win;

   logic [15:0] addr_q[$];
   logic [7:0]  pix_q[$];
   logic [10:0] win_q[$];

   conv1_frame_sched #(
      .WIDTH(28), .HEIGHT(28), .FILTER_SIZE(5),
      .DATA_BITS(8), .ADDR_BITS(16), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .img_base(img_base),
      .busy(busy), .done(done), .error(error),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .pix_out(pix_out), .pix_valid(pix_valid), .win_valid_in(win_valid_in),
      .out_valid(out_valid), .out_row(out_row), .out_col(out_col), .out_last(out_last)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   // Synchronous pixel memory: the data appears the cycle after the strobe.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= pat(mem_addr);
   end

   // Raster window-buffer model: it tracks the position of each pixel in the
   // image and reports a window once a full 5x5 neighbourhood has arrived.
   always @(posedge clk) begin
      if (!rst_n) pcnt <= 0;
      else if (pix_valid) pcnt <= (pcnt == NPIX - 1) ? 0 : pcnt + 1;
   end

   always_comb begin
      raster_win   = pix_valid && ((pcnt / 28) >= 4) && ((pcnt % 28) >= 4);
      win_valid_in = win_mode ? win_manual : raster_win;
   end

   // Scoreboard monitor: every read, pixel and window the DUT emits must
   // match the head of its queue.
   always @(negedge clk) begin
      logic [15:0] ea;
      logic [7:0]  ep;
      logic [10:0] ew;
      if (done) done_seen++;
      if (pix_valid) pv_seen++;
      if (sb_en) begin
         if (mem_rd_en) begin
            n_cmp++;
            if (addr_q.size() == 0) begin
               n_bad++;
               $display("[TB] FAIL rd_addr: got unexpected read %h, required none", mem_addr);
            end else begin
               ea = addr_q.pop_front();
               if (mem_addr !== ea) begin
                  n_bad++;
                  $display("[TB] FAIL rd_addr: got %h required %h", mem_addr, ea);
               end
            end
         end
         if (pix_valid) begin
            n_cmp++;
            if (pix_q.size() == 0) begin
               n_bad++;
               $display("[TB] FAIL pix: got unexpected pixel %h, required none", pix_out);
            end else begin
               ep = pix_q.pop_front();
               if (pix_out !== ep) begin
                  n_bad++;
                  $display("[TB] FAIL pix: got %h required %h", pix_out, ep);
               end
            end
         end
         if (out_valid) begin
            n_cmp++;
            if (win_q.size() == 0) begin
               n_bad++;
               $display("[TB] FAIL win: got unexpected window r%0d c%0d, required none", out_row, out_col);
            end else begin
               ew = win_q.pop_front();
               if ({out_last, out_row, out_col} !== ew) begin
                  n_bad++;
                  $display("[TB] FAIL win: got last=%0b r%0d c%0d required last=%0b r%0d c%0d",
                           out_last, out_row, out_col, ew[10], ew[9:5], ew[4:0]);
               end
            end
         end
      end
   end

   // Queue the full expected output of one frame: every address (modulo
   // 2^16), every pixel, and the first nwin windows in raster order.
   task automatic load_scoreboard(input logic [15:0] b, input int nwin);
      logic [15:0] a;
      for (int i = 0; i < NPIX; i++) begin
         a = b + 16'(i);
         addr_q.push_back(a);
         pix_q.push_back(pat(a));
      end
      for (int k = 0; k < nwin; k++) begin
         win_q.push_back({(k == NWIN - 1), 5'(k / 24), 5'(k % 24)});
      end
   endtask

   // Present start with the given base for one sampling edge. The task
   // returns just after the accepting edge, i.e. early in cycle T+1.
   task automatic applyStimulus(input logic [15:0] b);
      @(posedge clk); #1;
      img_base = b;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Wait, starting at a negedge, for the done pulse. The wait is bounded.
   task automatic wait_done(input int lim, output int waited, output bit got);
      got = 1'b0;
      waited = lim;
      for (int i = 0; i < lim; i++) begin
         if (done) begin
            got = 1'b1;
            waited = i;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      int pv0, d0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy, done, error, mem_rd_en, mem_addr, pix_out, pix_valid, out_valid, out_row, out_col, out_last} !== '0) begin
         n_bad++;
         $display("[TB] FAIL reset_outputs: got busy=%0b rd=%0b addr=%h pv=%0b, required all 0", busy, mem_rd_en, mem_addr, pix_valid);
      end
      @(posedge clk); #1 rst_n = 1'b1;

      load_scoreboard(16'h0200, NWIN);
      applyStimulus(16'h0200);
      repeat (100) @(posedge clk);
      #1;
      sb_en = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy, done, error, mem_rd_en, mem_addr, pix_out, pix_valid, out_valid, out_row, out_col, out_last} !== '0) begin
         n_bad++;
         $display("[TB] FAIL midframe_reset: got busy=%0b rd=%0b addr=%h pv=%0b, required all 0", busy, mem_rd_en, mem_addr, pix_valid);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      addr_q.delete();
      pix_q.delete();
      win_q.delete();
      sb_en = 1'b1;
      pv0 = pv_seen;
      d0 = done_seen;
      repeat (20) @(negedge clk);
      n_cmp++;
      if (pv_seen != pv0 || done_seen != d0 || busy !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL post_reset_quiet: got pv=%0d done=%0d busy=%0b, required 0 0 0", pv_seen - pv0, done_seen - d0, busy);
      end
   endtask

   task automatic test_single();
      int pv0, d0, waited;
      bit got;
      load_scoreboard(16'h0100, NWIN);
      pv0 = pv_seen;
      d0 = done_seen;
      applyStimulus(16'h0100);
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1 || mem_rd_en !== 1'b1 || mem_addr !== 16'h0100) begin
         n_bad++;
         $display("[TB] FAIL first_read: got busy=%0b rd=%0b addr=%h, required 1 1 0100", busy, mem_rd_en, mem_addr);
      end
      wait_done(2000, waited, got);
      n_cmp++;
      if (!got || waited != 785) begin
         n_bad++;
         $display("[TB] FAIL single_done_time: got %0d cycles (seen=%0b), required 785", waited, got);
      end
      n_cmp++;
      if (error !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL single_error: got %0b required 0", error);
      end
      @(negedge clk);
      n_cmp++;
      if (pv_seen - pv0 != NPIX || done_seen - d0 != 1 || busy !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL single_counts: got pv=%0d done=%0d busy=%0b, required 784 1 0", pv_seen - pv0, done_seen - d0, busy);
      end
      n_cmp++;
      if (addr_q.size() + pix_q.size() + win_q.size() != 0) begin
         n_bad++;
         $display("[TB] FAIL single_drained: got %0d/%0d/%0d left, required 0", addr_q.size(), pix_q.size(), win_q.size());
      end
   endtask

   task automatic test_start_busy();
      int d0, waited;
      bit got, quiet;
      load_scoreboard(16'h0000, NWIN);
      d0 = done_seen;
      applyStimulus(16'h0000);
      img_base = 16'hBEEF;
      repeat (9) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (389) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      wait_done(1000, waited, got);
      n_cmp++;
      if (!got) begin
         n_bad++;
         $display("[TB] FAIL busy_done_seen: got no done in %0d cycles, required done", waited);
      end
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      quiet = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (busy !== 1'b0 || mem_rd_en !== 1'b0) quiet = 1'b0;
      end
      n_cmp++;
      if (!quiet || done_seen - d0 != 1) begin
         n_bad++;
         $display("[TB] FAIL busy_ignored: got quiet=%0b done=%0d, required quiet=1 done=1", quiet, done_seen - d0);
      end
      n_cmp++;
      if (addr_q.size() + pix_q.size() + win_q.size() != 0) begin
         n_bad++;
         $display("[TB] FAIL busy_drained: got %0d left, required 0", addr_q.size() + pix_q.size() + win_q.size());
      end
   endtask

   task automatic test_back_to_back();
      int d0, pv0, waited;
      bit got;
      load_scoreboard(16'h0000, NWIN);
      load_scoreboard(16'd784, NWIN);
      d0 = done_seen;
      pv0 = pv_seen;
      @(posedge clk); #1;
      img_base = 16'h0000;
      start = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      wait_done(2000, waited, got);
      n_cmp++;
      if (!got || waited != 785) begin
         n_bad++;
         $display("[TB] FAIL b2b_first_done: got %0d cycles (seen=%0b), required 785", waited, got);
      end
      img_base = 16'd784;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL b2b_idle_gap: got busy=%0b rd=%0b, required 0 0", busy, mem_rd_en);
      end
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1 || mem_rd_en !== 1'b1 || mem_addr !== 16'd784) begin
         n_bad++;
         $display("[TB] FAIL b2b_second_start: got busy=%0b rd=%0b addr=%h, required 1 1 0310", busy, mem_rd_en, mem_addr);
      end
      wait_done(2000, waited, got);
      n_cmp++;
      if (!got || waited != 785) begin
         n_bad++;
         $display("[TB] FAIL b2b_second_done: got %0d cycles (seen=%0b), required 785", waited, got);
      end
      @(negedge clk);
      n_cmp++;
      if (done_seen - d0 != 2 || pv_seen - pv0 != 2 * NPIX || addr_q.size() + pix_q.size() + win_q.size() != 0) begin
         n_bad++;
         $display("[TB] FAIL b2b_counts: got done=%0d pv=%0d left=%0d, required 2 1568 0",
                  done_seen - d0, pv_seen - pv0, addr_q.size() + pix_q.size() + win_q.size());
      end
   endtask

   task automatic test_watchdog();
      int idx, waited;
      bit got;
      win_mode = 1'b1;
      load_scoreboard(16'h0300, 300);
      applyStimulus(16'h0300);
      repeat (499) @(posedge clk);
      #1 win_manual = 1'b1;
      repeat (300) @(posedge clk);
      #1 win_manual = 1'b0;
      // Window 299 was in cycle T+799 (DRAIN). After TIMEOUT idle cycles
      // the expiry edge ends cycle T+863, so error and done both read high
      // from cycle T+864, which is index TIMEOUT counting from T+800.
      idx = 200;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (error || done) begin
            idx = i;
            break;
         end
      end
      n_cmp++;
      if (idx != TIMEOUT || error !== 1'b1 || done !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL wdog_expiry: got cycle %0d err=%0b done=%0b, required %0d 1 1", idx, error, done, TIMEOUT);
      end
      @(negedge clk);
      n_cmp++;
      if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL wdog_sticky: got err=%0b busy=%0b done=%0b, required 1 0 0", error, busy, done);
      end
      n_cmp++;
      if (addr_q.size() + pix_q.size() + win_q.size() != 0) begin
         n_bad++;
         $display("[TB] FAIL wdog_drained: got %0d left, required 0", addr_q.size() + pix_q.size() + win_q.size());
      end
      win_mode = 1'b0;
      load_scoreboard(16'h0000, NWIN);
      applyStimulus(16'h0000);
      @(negedge clk);
      n_cmp++;
      if (error !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL wdog_clear: got %0b required 0", error);
      end
      wait_done(2000, waited, got);
      n_cmp++;
      if (!got || error !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL wdog_recover: got done=%0b err=%0b, required 1 0", got, error);
      end
      @(negedge clk);
   endtask

   task automatic test_wrap();
      int waited;
      bit got;
      load_scoreboard(16'hFFF0, NWIN);
      applyStimulus(16'hFFF0);
      @(negedge clk);
      wait_done(2000, waited, got);
      n_cmp++;
      if (!got || waited != 785 || error !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL wrap_done: got %0d cycles err=%0b, required 785 0", waited, error);
      end
      @(negedge clk);
      n_cmp++;
      if (addr_q.size() + pix_q.size() + win_q.size() != 0) begin
         n_bad++;
         $display("[TB] FAIL wrap_drained: got %0d left, required 0", addr_q.size() + pix_q.size() + win_q.size());
      end
   endtask

   initial begin
      $display("[TB] conv1_frame_sched bench starting");
      test_reset();
      test_single();
      test_start_busy();
      test_back_to_back();
      test_watchdog();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("[TB] FAIL global_timeout: got no finish by 400000, required finish");
      $fatal(1, "[TB] bench timed out");
   end

endmodule
